// File: rtl/mux5_scan_ctrl_pkg.sv
// Shared definitions for the 5-channel mux scan controller.
//   state_t  : controller states (IDLE / SCAN / DONE)
//   NCH      : number of mux channels
//   SEL_W    : width of the mux select code
//   CH0..CH4 : select codes driven for each channel, also collected in CH_CODE
package mux5_scan_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NCH   = 5;
  localparam int SEL_W = 3;

  localparam logic [SEL_W-1:0] CH0 = 3'd0;
  localparam logic [SEL_W-1:0] CH1 = 3'd1;
  localparam logic [SEL_W-1:0] CH2 = 3'd2;
  localparam logic [SEL_W-1:0] CH3 = 3'd3;
  localparam logic [SEL_W-1:0] CH4 = 3'd4;

  localparam logic [SEL_W-1:0] CH_CODE [NCH] = '{CH0, CH1, CH2, CH3, CH4};

endpackage

// File: rtl/mux5_next_chan.sv
// Combinational next-enabled-channel finder.
//   mask  : channel enable mask, bit k enables channel k
//   cur   : current channel as a signed code; -1 means "no channel yet",
//           which turns the block into a first-enabled-channel finder
//   nxt   : lowest enabled channel strictly above cur (CH0 when none)
//   found : high when such a channel exists
module mux5_next_chan
  import mux5_scan_ctrl_pkg::*;
(
  input  logic [NCH-1:0]          mask,
  input  logic signed [SEL_W:0]   cur,
  output logic [SEL_W-1:0]        nxt,
  output logic                    found
);

  // Scan from the top down so the lowest qualifying channel wins.
  always_comb begin
    nxt   = CH0;
    found = 1'b0;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (mask[k] && (k > int'(cur))) begin
        nxt   = CH_CODE[k];
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux5_scan_ctrl.sv
// Scan controller sitting upstream of a 5:1 mux. Steps the select through
// the enabled channels in ascending order, holds each for dwell+1 cycles,
// samples mux_y at the end of each hold and reports the collected bits.
//   clk, rst : clock and synchronous active-high reset
//   start    : scan request, only looked at in IDLE
//   dwell    : extra hold cycles per channel (latched at start)
//   ch_mask  : channel enables (latched at start)
//   mux_y    : mux output, combinational from sel
//   sel      : mux select code (0..4 only)
//   cap      : capture word, bit k = mux_y seen on channel k
//   busy     : high from the cycle after acceptance until back in IDLE
//   done     : one-cycle completion pulse; cap is stable from here on
module mux5_scan_ctrl
  import mux5_scan_ctrl_pkg::*;
#(
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [NCH-1:0]     ch_mask,
  input  logic               mux_y,
  output logic [SEL_W-1:0]   sel,
  output logic [NCH-1:0]     cap,
  output logic               busy,
  output logic               done
);

  state_t             state, state_d;
  logic [SEL_W-1:0]   sel_d;
  logic [NCH-1:0]     cap_d;
  logic [DWELL_W-1:0] cnt, cnt_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [NCH-1:0]     mask_q, mask_d;

  logic [SEL_W-1:0]   first_ch, next_ch;
  logic               first_found, next_found;

  // First channel is looked up from the live mask since it is chosen in
  // the same cycle the mask is latched.
  mux5_next_chan u_first (
    .mask  (ch_mask),
    .cur   ({(SEL_W+1){1'b1}}),
    .nxt   (first_ch),
    .found (first_found)
  );

  mux5_next_chan u_next (
    .mask  (mask_q),
    .cur   ({1'b0, sel}),
    .nxt   (next_ch),
    .found (next_found)
  );

  always_comb begin
    state_d = state;
    sel_d   = sel;
    cap_d   = cap;
    cnt_d   = cnt;
    dwell_d = dwell_q;
    mask_d  = mask_q;
    case (state)
      IDLE: begin
        if (start) begin
          cap_d = '0;
          if (first_found) begin
            mask_d  = ch_mask;
            dwell_d = dwell;
            sel_d   = first_ch;
            cnt_d   = dwell;
            state_d = SCAN;
          end else begin
            state_d = DONE;
          end
        end
      end
      SCAN: begin
        if (cnt != '0) begin
          cnt_d = cnt - 1'b1;
        end else begin
          for (int k = 0; k < NCH; k++) begin
            if (sel == CH_CODE[k]) cap_d[k] = mux_y;
          end
          if (next_found) begin
            sel_d = next_ch;
            cnt_d = dwell_q;
          end else begin
            // sel stays on the last channel through DONE
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sel   <= CH0;
      cap   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_d;
      sel   <= sel_d;
      cap   <= cap_d;
      cnt   <= cnt_d;
    end
  end

  // Latched scan parameters are pure data and need no reset.
  always_ff @(posedge clk) begin
    dwell_q <= dwell_d;
    mask_q  <= mask_d;
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_mux5_scan_ctrl.sv
module tb_mux5_scan_ctrl;
  import mux5_scan_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] dwell = '0;
  logic [4:0] ch_mask = '0;
  logic       mux_y;
  logic [2:0] sel;
  logic [4:0] cap;
  logic       busy;
  logic       done;

  logic [7:0] pat = '0;
  logic       noise = 1'b0;
  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;

  typedef struct {
    logic [4:0] cap;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   exp_sel[int];
  int   exp_busy[int];
  bit   final_cyc[int];
  int   last_sel = 0;

  mux5_scan_ctrl #(.DWELL_W(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .dwell   (dwell),
    .ch_mask (ch_mask),
    .mux_y   (mux_y),
    .sel     (sel),
    .cap     (cap),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Mux model: channel k returns pat[k]; noise disturbs every cycle except
  // the final cycle of a dwell window, so only a correctly timed sample is clean.
  assign mux_y = pat[sel] ^ noise;

  always @(posedge clk) begin
    #1;
    noise = final_cyc.exists(cyc) ? 1'b0 : 1'($urandom_range(0, 1));
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: enabled channels in ascending order, each dwell+1 cycles.
  task automatic model_scan(input int e0, input logic [3:0] d, input logic [4:0] m);
    int   t;
    exp_t e;
    t     = e0;
    e.cap = '0;
    if (m == 5'd0) exp_sel[e0] = last_sel;
    for (int k = 0; k < 5; k++) begin
      if (m[k]) begin
        for (int j = 0; j <= int'(d); j++) begin
          exp_sel[t + j]  = k;
          exp_busy[t + j] = 1;
        end
        final_cyc[t + int'(d)] = 1'b1;
        e.cap[k] = pat[k];
        t += int'(d) + 1;
        last_sel = k;
      end
    end
    exp_sel[t]      = last_sel;
    exp_busy[t]     = 1;
    exp_busy[t + 1] = 0;
    e.cyc = t;
    sb.push_back(e);
  endtask

  task automatic purge_from(input int c);
    int keys[$];
    keys.delete();
    foreach (exp_sel[k]) if (k >= c) keys.push_back(k);
    foreach (keys[i]) exp_sel.delete(keys[i]);
    keys.delete();
    foreach (exp_busy[k]) if (k >= c) keys.push_back(k);
    foreach (keys[i]) exp_busy.delete(keys[i]);
    keys.delete();
    foreach (final_cyc[k]) if (k >= c) keys.push_back(k);
    foreach (keys[i]) final_cyc.delete(keys[i]);
  endtask

  task automatic issue_scan(input logic [3:0] d, input logic [4:0] m, input logic [7:0] p);
    @(posedge clk); #1;
    pat     = p;
    start   = 1'b1;
    dwell   = d;
    ch_mask = m;
    model_scan(cyc + 1, d, m);
    @(posedge clk); #1;
    start   = 1'b0;
    dwell   = 4'($urandom);
    ch_mask = 5'($urandom);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 120) begin
      @(posedge clk); #1;
      n++;
    end
    check("returned_idle", busy, 0);
  endtask

  // Monitor: compares sel/busy timeline and pops the scoreboard on done.
  always @(negedge clk) begin
    exp_t e;
    if (cyc > 0) begin
      if (exp_sel.exists(cyc))  check("sel", sel, exp_sel[cyc]);
      if (exp_busy.exists(cyc)) check("busy", busy, exp_busy[cyc]);
      if (sb.size() > 0 && cyc == sb[0].cyc) begin
        e = sb.pop_front();
        check("done", done, 1);
        check("cap", cap, e.cap);
      end else begin
        check("done_quiet", done, 0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_sel", sel, 0);
    check("rst_cap", cap, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst = 1'b0;

    // empty mask goes straight to DONE, sel untouched
    issue_scan(4'd3, 5'b00000, 8'h1f);
    wait_idle();

    // all channels, no dwell, channel k returns k[0]
    issue_scan(4'd0, 5'b11111, 8'b0000_1010);
    wait_idle();

    // sparse mask with dwell
    issue_scan(4'd2, 5'b10100, 8'h1f);
    wait_idle();

    // extra start with different settings mid-scan must be ignored
    issue_scan(4'd3, 5'b01101, 8'($urandom));
    repeat (3) @(posedge clk);
    #1;
    start   = 1'b1;
    dwell   = 4'd1;
    ch_mask = 5'b10010;
    @(posedge clk); #1;
    start   = 1'b0;
    wait_idle();

    // reset while on channel 2
    issue_scan(4'd3, 5'b11111, 8'($urandom));
    n = 0;
    while (sel !== 3'd2 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("reached_ch2", sel, 2);
    purge_from(cyc + 1);
    sb.delete();
    last_sel = 0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_sel", sel, 0);
    check("midrst_cap", cap, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    issue_scan(4'd2, 5'b11111, 8'($urandom));
    wait_idle();

    // maximum dwell on a single channel
    issue_scan(4'd15, 5'b00001, 8'($urandom));
    wait_idle();

    repeat (20) begin
      issue_scan(4'($urandom_range(0, 15)), 5'($urandom_range(0, 31)), 8'($urandom));
      wait_idle();
    end

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
